// File: rtl/u_swap_seq.sv
// rtl/u_swap_seq.sv - u-flag pulse sequencer and final-u capture for the modular-division loop
// Drives u_flag_rst/u_flag_set, mirrors the flag, and returns the final u over valid/ready.
module u_swap_seq #(
   parameter int WIDTH    = 32,
   parameter int MAX_ITER = 64,
   parameter int CNT_W    = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step_req,
   input  logic             finish,
   input  logic [WIDTH-1:0] regu_q,
   input  logic [WIDTH-1:0] regt_q,
   output logic             u_flag_rst,
   output logic             u_flag_set,
   output logic             u_flag_m,
   output logic [WIDTH-1:0] u_cur,
   output logic             busy,
   output logic [CNT_W-1:0] iter_cnt,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

   state_t state;

   assign u_cur = u_flag_m ? regu_q : regt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         u_flag_rst   <= 1'b0;
         u_flag_set   <= 1'b0;
         u_flag_m     <= 1'b1;
         busy         <= 1'b0;
         iter_cnt     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         u_flag_rst <= 1'b0;
         u_flag_set <= 1'b0;
         // The flag register toggles on the edge that sees our set pulse; follow it there.
         if (u_flag_set) begin
            u_flag_m <= ~u_flag_m;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= INIT;
                  iter_cnt   <= '0;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  u_flag_rst <= 1'b1;
               end
            end
            INIT: begin
               u_flag_m <= 1'b1;
               state    <= RUN;
            end
            RUN: begin
               if (finish) begin
                  result       <= u_cur;
                  result_valid <= 1'b1;
                  state        <= OUT;
               end else if (step_req) begin
                  if (iter_cnt < ITER_LIMIT) begin
                     u_flag_set <= 1'b1;
                     iter_cnt   <= iter_cnt + CNT_W'(1);
                  end else begin
                     err          <= 1'b1;
                     result       <= '0;
                     result_valid <= 1'b1;
                     state        <= OUT;
                  end
               end
            end
            OUT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_u_swap_seq.sv
// tb/tb_u_swap_seq.sv - randomized scoreboard bench for u_swap_seq
// Stimulus pushes expected results; a negedge monitor pops them on each result handshake.
module tb_u_swap_seq;
   localparam int WIDTH    = 32;
   localparam int MAX_ITER = 64;
   localparam int CNT_W    = 7;

   logic             clk = 1'b0;
   logic             rst_n, start, step_req, finish, result_ready;
   logic [WIDTH-1:0] regu_q, regt_q;
   logic             u_flag_rst, u_flag_set, u_flag_m, busy, result_valid, err;
   logic [WIDTH-1:0] u_cur, result;
   logic [CNT_W-1:0] iter_cnt;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             e;
      int               iters;
      int               sets;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   set_seen = 0;
   int   rst_seen = 0;
   logic             prev_hold = 1'b0;
   logic [WIDTH-1:0] prev_res;
   logic             prev_err;

   u_swap_seq #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .step_req(step_req), .finish(finish),
      .regu_q(regu_q), .regt_q(regt_q), .u_flag_rst(u_flag_rst), .u_flag_set(u_flag_set),
      .u_flag_m(u_flag_m), .u_cur(u_cur), .busy(busy), .iter_cnt(iter_cnt), .result(result),
      .result_valid(result_valid), .result_ready(result_ready), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pulse bookkeeping, hold stability, and scoreboard pops on handshake.
   always @(negedge clk) begin
      chk("pulse_exclusive", {63'b0, u_flag_rst & u_flag_set}, 64'd0);
      chk("u_cur_select", u_cur, u_flag_m ? regu_q : regt_q);
      if (u_flag_rst) begin
         rst_seen++;
         set_seen = 0;
      end
      if (u_flag_set) set_seen++;
      if (prev_hold && rst_n) begin
         chk("result_stable", result, prev_res);
         chk("err_stable", err, prev_err);
         chk("valid_stable", result_valid, 1);
      end
      if (result_valid && result_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0h expected none", result);
         end else begin
            mon_e = sb.pop_front();
            chk("result", result, mon_e.res);
            chk("err", err, mon_e.e);
            chk("iter_cnt", iter_cnt, mon_e.iters);
            chk("set_pulses", set_seen, mon_e.sets);
         end
      end
      prev_hold = rst_n && result_valid && !result_ready;
      prev_res  = result;
      prev_err  = err;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      regu_q = $urandom;
      regt_q = $urandom;
   endtask

   task automatic start_op();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rst_pulse", u_flag_rst, 1);
      chk("busy_init", busy, 1);
      chk("err_cleared", err, 0);
      chk("iter_cleared", iter_cnt, 0);
      tick();
      chk("rst_pulse_width", u_flag_rst, 0);
      chk("mirror_after_init", u_flag_m, 1);
   endtask

   // Model: u starts in regu and moves on every accepted step; the 65th step aborts.
   task automatic run_op(input int n, input bit gaps, input bit step_with_finish,
                         input int ready_wait, input bit start_in_out,
                         input bit force_vals, input logic [WIDTH-1:0] fu,
                         input logic [WIDTH-1:0] ft);
      int   acc;
      int   rst_before;
      bit   abort;
      exp_t e;
      acc   = 0;
      abort = 1'b0;
      start_op();
      for (int i = 0; i < n; i++) begin
         step_req = 1'b1;
         if (acc == MAX_ITER) begin
            abort   = 1'b1;
            e.res   = '0;
            e.e     = 1'b1;
            e.iters = MAX_ITER;
            e.sets  = MAX_ITER;
            sb.push_back(e);
         end else begin
            acc++;
         end
         tick();
         step_req = 1'b0;
         if (abort) break;
         if (gaps && $urandom_range(0, 1) == 1) tick();
      end
      if (!abort) begin
         tick();
         if (force_vals) begin
            regu_q = fu;
            regt_q = ft;
         end
         finish   = 1'b1;
         step_req = step_with_finish;
         e.res    = (acc % 2 == 0) ? regu_q : regt_q;
         e.e      = 1'b0;
         e.iters  = acc;
         e.sets   = acc;
         sb.push_back(e);
         tick();
         finish   = 1'b0;
         step_req = 1'b0;
      end
      chk("valid_latency", result_valid, 1);
      chk("mirror_final", u_flag_m, (acc % 2 == 0) ? 1 : 0);
      rst_before = rst_seen;
      for (int k = 0; k < ready_wait; k++) begin
         start = (start_in_out && k == 3);
         tick();
      end
      start        = start_in_out;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      start        = 1'b0;
      chk("valid_drop", result_valid, 0);
      chk("busy_idle", busy, 0);
      tick();
      chk("start_ignored_busy", busy, 0);
      chk("start_ignored_rst", rst_seen, rst_before);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; step_req = 1'b0; finish = 1'b0; result_ready = 1'b0;
      regu_q = '0; regt_q = '0;
      tick(); tick();
      chk("reset_flag_m", u_flag_m, 1);
      chk("reset_valid", result_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_iter", iter_cnt, 0);
      chk("reset_busy_err", {busy, err, u_flag_rst, u_flag_set}, 0);
      rst_n = 1'b1;
      tick();

      run_op(0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
      run_op(3, 1'b1, 1'b0, 1, 1'b0, 1'b1, 32'h5555_0000, 32'h0000_00A5);
      run_op(1, 1'b1, 1'b1, 0, 1'b0, 1'b0, '0, '0);
      run_op(MAX_ITER + 1, 1'b0, 1'b0, 2, 1'b0, 1'b0, '0, '0);
      run_op(2, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0, '0);
      run_op(4, 1'b1, 1'b0, 10, 1'b1, 1'b0, '0, '0);
      for (int r = 0; r < 10; r++) begin
         run_op($urandom_range(0, 12), 1'b1, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, '0, '0);
      end

      start_op();
      for (int i = 0; i < 5; i++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         if (i < 4) tick();
      end
      chk("pending_set_before_reset", u_flag_set, 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_set", u_flag_set, 0);
      chk("async_reset_mirror", u_flag_m, 1);
      chk("async_reset_iter", iter_cnt, 0);
      chk("async_reset_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_pulses", {u_flag_rst, u_flag_set}, 0);
      chk("post_reset_mirror", u_flag_m, 1);
      chk("post_reset_valid", {result_valid, err}, 0);

      run_op(MAX_ITER + 3, 1'b0, 1'b0, 1, 1'b0, 1'b0, '0, '0);
      run_op(5, 1'b1, 1'b0, 1, 1'b0, 1'b0, '0, '0);
      tick(); tick();
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
